// File: rtl/sdram_req_arbiter.sv
// Arbitrates the single sdrc_core application port between the video refill reader
// and the FTDI host writer, sequencing each transfer and bounding write starvation.
module sdram_req_arbiter #(
   parameter int AW         = 25,
   parameter int RD_LEN     = 8,
   parameter int GUARD_CYC  = 2,
   parameter int STARVE_MAX = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic          mem_clk,
   input  logic          reset,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_ack,
   input  logic          wr_req,
   input  logic [AW-1:0] wr_addr,
   output logic          wr_ack,
   output logic          wr_data_next,
   output logic          app_req,
   output logic [AW-1:0] app_req_addr,
   output logic [8:0]    app_req_len,
   output logic          app_req_wr_n,
   output logic          app_req_dma_last,
   input  logic          app_req_ack,
   input  logic          app_rd_valid,
   input  logic          app_last_rd,
   input  logic          app_last_wr,
   input  logic          app_wr_next_req,
   output logic          busy,
   output logic          timeout_err,
   output logic [2:0]    state_dbg
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_DATA = 3'd4,
      GUARD   = 3'd5
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [AW-1:0] addr_q;
   logic [8:0]    beat_cnt;
   logic [7:0]    cyc_cnt;
   logic [SW-1:0] starve_cnt;
   logic          rd_done;
   logic          data_timeout;
   logic          abort;

   // Next state and all port-side outputs; cyc_cnt doubles as data-phase timeout and guard timer.
   always_comb begin
      state_next       = state;
      abort            = 1'b0;
      rd_done          = app_last_rd || (app_rd_valid && beat_cnt == 9'(RD_LEN - 1));
      data_timeout     = (cyc_cnt == 8'(TIMEOUT - 1));
      app_req          = 1'b0;
      app_req_addr     = '0;
      app_req_len      = '0;
      app_req_wr_n     = 1'b1;
      app_req_dma_last = 1'b0;
      rd_ack           = 1'b0;
      wr_ack           = 1'b0;
      wr_data_next     = 1'b0;
      case (state)
         IDLE: begin
            if (wr_req && starve_cnt == SW'(STARVE_MAX)) state_next = WR_REQ;
            else if (rd_req) state_next = RD_REQ;
            else if (wr_req) state_next = WR_REQ;
         end
         RD_REQ: begin
            app_req          = 1'b1;
            app_req_addr     = addr_q;
            app_req_len      = 9'(RD_LEN);
            app_req_dma_last = 1'b1;
            rd_ack           = app_req_ack && !reset;
            if (app_req_ack) state_next = RD_DATA;
         end
         RD_DATA: begin
            if (rd_done) begin
               state_next = GUARD;
            end else if (data_timeout) begin
               state_next = GUARD;
               abort      = 1'b1;
            end
         end
         WR_REQ: begin
            app_req      = 1'b1;
            app_req_addr = addr_q;
            app_req_len  = 9'd1;
            app_req_wr_n = 1'b0;
            wr_ack       = app_req_ack && !reset;
            if (app_req_ack) state_next = WR_DATA;
         end
         WR_DATA: begin
            wr_data_next = app_wr_next_req;
            if (app_last_wr) begin
               state_next = GUARD;
            end else if (data_timeout) begin
               state_next = GUARD;
               abort      = 1'b1;
            end
         end
         GUARD: begin
            if (cyc_cnt == 8'(GUARD_CYC - 1)) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register plus address capture, beat/cycle counters and starvation accounting.
   always_ff @(posedge mem_clk) begin
      if (reset) begin
         state       <= IDLE;
         addr_q      <= '0;
         beat_cnt    <= '0;
         cyc_cnt     <= '0;
         starve_cnt  <= '0;
         timeout_err <= 1'b0;
      end else begin
         state   <= state_next;
         cyc_cnt <= (state_next != state) ? 8'd0 : cyc_cnt + 8'd1;
         if (state == IDLE) begin
            if (state_next == WR_REQ) addr_q <= wr_addr;
            else if (state_next == RD_REQ) addr_q <= rd_addr;
         end
         if (state != RD_DATA) beat_cnt <= '0;
         else if (app_rd_valid) beat_cnt <= beat_cnt + 9'd1;
         // Only reads accepted while a write waits count toward the starvation limit.
         if (state == RD_REQ && app_req_ack && wr_req && starve_cnt != SW'(STARVE_MAX))
            starve_cnt <= starve_cnt + SW'(1);
         else if (state == WR_REQ && app_req_ack)
            starve_cnt <= '0;
         if (abort) timeout_err <= 1'b1;
      end
   end

   assign busy      = (state != IDLE);
   assign state_dbg = state;

endmodule
